// File: rtl/seq_gen_pkg.sv
// Shared encodings and constants for the serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  localparam int FRAME_CNT_W = 8;
  localparam logic [FRAME_CNT_W-1:0] FRAME_CNT_MAX = 8'hFF;

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts 0..BIT_DIV-1 while enabled, flags mid-bit and last cycle.
module bit_timer #(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic mid,
  output logic last
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      div_d = (div_q == DW'(BIT_DIV - 1)) ? '0 : div_q + DW'(1);
    end
  end

  assign mid  = en && (div_q == DW'(BIT_DIV / 2));
  assign last = en && (div_q == DW'(BIT_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serialises a captured pattern MSB-first with a mid-bit step strobe,
// optional repeat with inter-frame gap, abort, and a saturating frame counter.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W    = 8,
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 1,
  localparam int LW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             repeat_en,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic             seq_out,
  output logic             step,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt
);

  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  state_e                 state_q, state_d;
  logic [PAT_W-1:0]       pat_q, pat_d;     // captured pattern, left-aligned to the MSB
  logic [PAT_W-1:0]       shift_q, shift_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          bit_idx_q, bit_idx_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   seq_out_q, seq_out_d;
  logic                   done_q, done_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  logic             tmr_clr, tmr_en, tmr_mid, tmr_last;
  logic [LW-1:0]    eff_len;
  logic [LW-1:0]    shamt;
  logic [PAT_W-1:0] aligned;

  bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .mid  (tmr_mid),
    .last (tmr_last)
  );

  // Out-of-range or zero length means "send the whole pattern".
  assign eff_len = ((len == '0) || (len > LW'(PAT_W))) ? LW'(PAT_W) : len;
  assign shamt   = LW'(PAT_W) - eff_len;
  assign aligned = pattern << shamt;

  assign tmr_en  = (state_q != ST_IDLE);
  assign tmr_clr = (state_q == ST_IDLE) || stop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shift_d   = shift_q;
    len_d     = len_q;
    bit_idx_d = bit_idx_q;
    gap_d     = gap_q;
    seq_out_d = seq_out_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        seq_out_d = 1'b0;
        if (start && !stop) begin
          state_d   = ST_SEND;
          pat_d     = aligned;
          len_d     = eff_len;
          seq_out_d = aligned[PAT_W-1];
          shift_d   = aligned << 1;
          bit_idx_d = eff_len - LW'(1);
        end
      end

      ST_SEND: begin
        if (stop) begin
          state_d   = ST_IDLE;
          seq_out_d = 1'b0;
        end else if (tmr_last) begin
          if (bit_idx_q == '0) begin
            if (cnt_q != FRAME_CNT_MAX) cnt_d = cnt_q + FRAME_CNT_W'(1);
            if (!repeat_en) begin
              state_d   = ST_IDLE;
              seq_out_d = 1'b0;
              done_d    = 1'b1;
            end else if (GAP_BITS > 0) begin
              state_d   = ST_GAP;
              seq_out_d = 1'b0;
              gap_d     = '0;
            end else begin
              seq_out_d = pat_q[PAT_W-1];
              shift_d   = pat_q << 1;
              bit_idx_d = len_q - LW'(1);
            end
          end else begin
            seq_out_d = shift_q[PAT_W-1];
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q - LW'(1);
          end
        end
      end

      ST_GAP: begin
        seq_out_d = 1'b0;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tmr_last) begin
          if (gap_q == GW'(GAP_BITS - 1)) begin
            state_d   = ST_SEND;
            seq_out_d = pat_q[PAT_W-1];
            shift_d   = pat_q << 1;
            bit_idx_d = len_q - LW'(1);
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        seq_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      seq_out_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
      seq_out_q <= seq_out_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign seq_out   = seq_out_q;
  assign step      = (state_q == ST_SEND) && tmr_mid;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-cycle traces compared against hand-derived vectors.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, repeat_en;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       seq_out, step, busy, done;
  logic [7:0] frame_cnt;

  logic       start2, stop2, repeat_en2;
  logic [7:0] pattern2;
  logic [3:0] len2;
  logic       seq_out2, step2, busy2, done2;
  logic [7:0] frame_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] v_seq, v_step, v_busy, v_done;
  logic [7:0]  cnt_at [64];

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(8), .BIT_DIV(4), .GAP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_en(repeat_en),
    .pattern(pattern), .len(len), .seq_out(seq_out), .step(step), .busy(busy),
    .done(done), .frame_cnt(frame_cnt)
  );

  seq_pattern_gen #(.PAT_W(8), .BIT_DIV(4), .GAP_BITS(0)) dut_b2b (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .repeat_en(repeat_en2),
    .pattern(pattern2), .len(len2), .seq_out(seq_out2), .step(step2), .busy(busy2),
    .done(done2), .frame_cnt(frame_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected seq_out trace: L bits of pat, MSB-first, 4 cycles each, starting at cycle off.
  function automatic logic [63:0] exp_seq(input logic [7:0] pat, input int l, input int off);
    logic [63:0] v = '0;
    for (int i = 0; i < l; i++)
      for (int c = 0; c < 4; c++)
        v[off + 4*i + c] = pat[l-1-i];
    return v;
  endfunction

  function automatic logic [63:0] exp_step(input int l, input int off);
    logic [63:0] v = '0;
    for (int i = 0; i < l; i++) v[off + 4*i + 2] = 1'b1;
    return v;
  endfunction

  // Caller raises start in cycle 0; this records cycles 1..n_cyc. Event cycles of 0 mean none.
  task automatic run(input int n_cyc, input int start_at, input int stop_at,
                     input int pchg_at, input int rep_off_at);
    v_seq = '0; v_step = '0; v_busy = '0; v_done = '0;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge clk); #1;
      start = (k == start_at);
      stop  = (k == stop_at);
      if (k == pchg_at) pattern = ~pattern;
      if (k == rep_off_at) repeat_en = 1'b0;
      v_seq[k]  = seq_out;
      v_step[k] = step;
      v_busy[k] = busy;
      v_done[k] = done;
      cnt_at[k] = frame_cnt;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic begin_frame(input logic [7:0] pat, input logic [3:0] l, input logic rep);
    pattern = pat; len = l; repeat_en = rep; start = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; repeat_en = 0; pattern = '0; len = '0;
    start2 = 0; stop2 = 0; repeat_en2 = 0; pattern2 = '0; len2 = '0;
    #12;
    check("rst_outputs", {seq_out, step, busy, done, frame_cnt}, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, 0x0D, len 4
    begin_frame(8'h0D, 4'd4, 1'b0);
    run(20, 0, 0, 0, 0);
    check("single_seq",  v_seq,  64'h1_E1FE);
    check("single_step", v_step, 64'h8888);
    check("single_busy", v_busy, 64'h1_FFFE);
    check("single_done", v_done, 64'h2_0000);
    check("single_cnt",  cnt_at[17], 8'd1);

    // Repeat with one gap bit; repeat_en dropped during the second frame
    begin_frame(8'h0D, 4'd4, 1'b1);
    run(40, 0, 0, 0, 25);
    check("rep_seq",   v_seq,  64'h1E_1FE1_E1FE);
    check("rep_step",  v_step, 64'h8_8880_8888);
    check("rep_busy",  v_busy, 64'h1F_FFFF_FFFE);
    check("rep_done",  v_done, 64'h20_0000_0000);
    check("rep_cnt17", cnt_at[17], 8'd2);
    check("rep_cnt37", cnt_at[37], 8'd3);

    // Abort in cycle 6
    begin_frame(8'h0D, 4'd4, 1'b0);
    run(20, 0, 6, 0, 0);
    check("abort_seq",  v_seq,  64'h7E);
    check("abort_step", v_step, 64'h8);
    check("abort_busy", v_busy, 64'h7E);
    check("abort_done", v_done, 64'h0);
    check("abort_cnt",  cnt_at[20], 8'd3);

    // len=0 sends all eight bits
    begin_frame(8'hA5, 4'd0, 1'b0);
    run(36, 0, 0, 0, 0);
    check("len0_seq",  v_seq,  exp_seq(8'hA5, 8, 1));
    check("len0_step", v_step, exp_step(8, 1));
    check("len0_busy", v_busy, 64'h1_FFFF_FFFE);
    check("len0_done", v_done, 64'h2_0000_0000);

    // len=9 clamps to 8; start during busy and pattern change mid-frame are ignored
    begin_frame(8'h3C, 4'd9, 1'b0);
    run(36, 10, 0, 5, 0);
    check("len9_seq",  v_seq,  exp_seq(8'h3C, 8, 1));
    check("len9_busy", v_busy, 64'h1_FFFF_FFFE);
    check("len9_done", v_done, 64'h2_0000_0000);
    check("len9_cnt",  cnt_at[36], 8'd5);

    // Asynchronous reset mid-frame
    begin_frame(8'hA5, 4'd8, 1'b0);
    run(10, 0, 0, 0, 0);
    check("pre_rst_busy", {busy, seq_out}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", {seq_out, step, busy, done, frame_cnt}, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    begin_frame(8'h0D, 4'd4, 1'b0);
    run(20, 0, 0, 0, 0);
    check("post_rst_seq",  v_seq,  64'h1_E1FE);
    check("post_rst_done", v_done, 64'h2_0000);
    check("post_rst_cnt",  cnt_at[20], 8'd1);

    // Back-to-back repeats (no gap), len=2 pattern 10b: frame n ends at cycle 8n
    pattern2 = 8'h02; len2 = 4'd2; repeat_en2 = 1'b1; start2 = 1'b1;
    for (int k = 1; k <= 8 * 260 + 1; k++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (k == 4)  check("b2b_bit1", seq_out2, 1'b1);
      if (k == 8)  check("b2b_bit0", seq_out2, 1'b0);
      if (k == 9)  check("b2b_restart", {seq_out2, busy2, done2}, 3'b110);
      if (k == 8 * 254 + 1) check("b2b_cnt254", frame_cnt2, 8'd254);
    end
    check("b2b_sat", frame_cnt2, 8'd255);
    stop2 = 1'b1;
    @(posedge clk); #1;
    stop2 = 1'b0;
    check("b2b_stop", {busy2, seq_out2, done2, frame_cnt2}, {3'b000, 8'd255});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
